// File: rtl/disp_scroll_buf_if.sv
// Message-write, commit/scroll control and digit-read bus of disp_scroll_buf.
// master drives writes, commits and digit requests; slave returns glyphs and step ticks.
interface disp_scroll_buf_if;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [5:0]  wr_char;
   logic        commit;
   logic [5:0]  commit_len;
   logic        scroll_en;
   logic [3:0]  rd_digit;
   logic [13:0] rd_segm;
   logic        step_tick;

   modport master (
      output wr_en, wr_addr, wr_char, commit, commit_len, scroll_en, rd_digit,
      input  rd_segm, step_tick
   );

   modport slave (
      input  wr_en, wr_addr, wr_char, commit, commit_len, scroll_en, rd_digit,
      output rd_segm, step_tick
   );
endinterface

// File: rtl/disp_scroll_buf.sv
// Scrolling 14-segment message buffer: 32x6 message RAM, registered glyph lookup per scanned digit.
// Macro SCROLL_PINGPONG_EN: offset bounces between 0 and len-NDIG instead of wrapping modulo len.
module disp_scroll_buf #(
   parameter int unsigned SCROLL_DIV = 1000000,
   parameter int unsigned NDIG       = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   disp_scroll_buf_if.slave bus
);

   localparam int unsigned      DIV_W    = $clog2(SCROLL_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);
   localparam logic [5:0]       NDIG_L   = 6'(NDIG);
   localparam logic [5:0]       MAX_LEN  = 6'd32;

   // Segment order, MSB first: a b c d e f g1 g2 h i j k l m
   function automatic logic [13:0] font14(input logic [5:0] code);
      logic [13:0] g;
      g = '0;
      case (code)
         6'h00: g = 14'b000000_00_000000; // space
         6'h01: g = 14'b111011_11_000000; // A
         6'h02: g = 14'b111100_01_010010; // B
         6'h03: g = 14'b100111_00_000000; // C
         6'h04: g = 14'b111100_00_010010; // D
         6'h05: g = 14'b100111_10_000000; // E
         6'h06: g = 14'b100011_10_000000; // F
         6'h07: g = 14'b101111_01_000000; // G
         6'h08: g = 14'b011011_11_000000; // H
         6'h09: g = 14'b100100_00_010010; // I
         6'h0A: g = 14'b011110_00_000000; // J
         6'h0B: g = 14'b000011_10_001001; // K
         6'h0C: g = 14'b000111_00_000000; // L
         6'h0D: g = 14'b011011_00_101000; // M
         6'h0E: g = 14'b011011_00_100001; // N
         6'h0F: g = 14'b111111_00_000000; // O
         6'h10: g = 14'b110011_11_000000; // P
         6'h11: g = 14'b111111_00_000001; // Q
         6'h12: g = 14'b110011_11_000001; // R
         6'h13: g = 14'b101101_11_000000; // S
         6'h14: g = 14'b100000_00_010010; // T
         6'h15: g = 14'b011111_00_000000; // U
         6'h16: g = 14'b000011_00_001100; // V
         6'h17: g = 14'b011011_00_000101; // W
         6'h18: g = 14'b000000_00_101101; // X
         6'h19: g = 14'b000000_00_101010; // Y
         6'h1A: g = 14'b100100_00_001100; // Z
         6'h1B: g = 14'b101010_11_000000; // N-tilde
         6'h1C: g = 14'b111111_00_001100; // 0
         6'h1D: g = 14'b011000_00_001000; // 1
         6'h1E: g = 14'b110110_11_000000; // 2
         6'h1F: g = 14'b111100_11_000000; // 3
         6'h20: g = 14'b011001_11_000000; // 4
         6'h21: g = 14'b100101_10_000001; // 5
         6'h22: g = 14'b101111_11_000000; // 6
         6'h23: g = 14'b111000_00_000000; // 7
         6'h24: g = 14'b111111_11_000000; // 8
         6'h25: g = 14'b111101_11_000000; // 9
         default: g = '0;
      endcase
      return g;
   endfunction

`ifdef SCROLL_PINGPONG_EN
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   dir_e dir_q, dir_d;
`endif

   logic [5:0]       msg_q [32];
   logic [5:0]       len_q, len_d;
   logic [4:0]       offset_q, offset_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_q, tick_d;
   logic [13:0]      segm_q, segm_d;

   logic [5:0]       digit;
   logic [5:0]       sum;
   logic [4:0]       idx;
   logic             blank;
   logic             scrolling;

   // RAM contents are never reset: len=0 blanks every digit until a commit.
   always_ff @(posedge clk) begin
      if (bus.wr_en) begin
         msg_q[bus.wr_addr] <= bus.wr_char;
      end
   end

   assign digit     = {2'b00, bus.rd_digit};
   assign sum       = {1'b0, offset_q} + digit;
   assign scrolling = (len_q > NDIG_L);

   // offset < len and digit < NDIG < len, so one conditional subtract wraps sum.
   always_comb begin
      idx = 5'(digit);
      if (scrolling) begin
         idx = (sum >= len_q) ? 5'(sum - len_q) : 5'(sum);
      end
      blank = (digit >= NDIG_L) || (len_q == 6'd0) || (digit >= len_q);
   end

   always_comb begin
      len_d    = len_q;
      offset_d = offset_q;
      div_d    = div_q;
      tick_d   = 1'b0;
      segm_d   = blank ? 14'b0 : font14(msg_q[idx]);
`ifdef SCROLL_PINGPONG_EN
      dir_d    = dir_q;
`endif
      if (bus.commit) begin
         len_d    = (bus.commit_len > MAX_LEN) ? MAX_LEN : bus.commit_len;
         offset_d = '0;
         div_d    = '0;
`ifdef SCROLL_PINGPONG_EN
         dir_d    = DIR_UP;
`endif
      end else if (bus.scroll_en && scrolling) begin
         if (div_q == DIV_LAST) begin
            div_d  = '0;
            tick_d = 1'b1;
`ifdef SCROLL_PINGPONG_EN
            // A reversal is itself a step, so the turn-around position is shown once.
            if (dir_q == DIR_UP) begin
               if ({1'b0, offset_q} == (len_q - NDIG_L)) begin
                  dir_d    = DIR_DOWN;
                  offset_d = offset_q - 5'd1;
               end else begin
                  offset_d = offset_q + 5'd1;
               end
            end else begin
               if (offset_q == 5'd0) begin
                  dir_d    = DIR_UP;
                  offset_d = offset_q + 5'd1;
               end else begin
                  offset_d = offset_q - 5'd1;
               end
            end
`else
            offset_d = ({1'b0, offset_q} == (len_q - 6'd1)) ? 5'd0 : offset_q + 5'd1;
`endif
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q    <= '0;
         offset_q <= '0;
         div_q    <= '0;
         tick_q   <= 1'b0;
         segm_q   <= '0;
`ifdef SCROLL_PINGPONG_EN
         dir_q    <= DIR_UP;
`endif
      end else begin
         len_q    <= len_d;
         offset_q <= offset_d;
         div_q    <= div_d;
         tick_q   <= tick_d;
         segm_q   <= segm_d;
`ifdef SCROLL_PINGPONG_EN
         dir_q    <= dir_d;
`endif
      end
   end

   assign bus.rd_segm   = segm_q;
   assign bus.step_tick = tick_q;

endmodule

// File: tb/tb_disp_scroll_buf.sv
// Randomized bench for disp_scroll_buf against a step-count reference model of the scrolling display.
module tb_disp_scroll_buf;
   localparam int SCROLL_DIV = 4;
   localparam int NDIG       = 12;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   disp_scroll_buf_if bus();

   disp_scroll_buf #(.SCROLL_DIV(SCROLL_DIV), .NDIG(NDIG)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: message copy, length, active divider cycles and scroll steps since commit.
   logic [5:0] mem_m [32];
   int len_m   = 0;
   int cyc_m   = 0;
   int steps_m = 0;
   int tick_cnt;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] font_ref(input logic [5:0] c);
      case (c)
         6'h01: return 14'b11101111000000;
         6'h02: return 14'b11110001010010;
         6'h03: return 14'b10011100000000;
         6'h04: return 14'b11110000010010;
         6'h05: return 14'b10011110000000;
         6'h06: return 14'b10001110000000;
         6'h07: return 14'b10111101000000;
         6'h08: return 14'b01101111000000;
         6'h09: return 14'b10010000010010;
         6'h0A: return 14'b01111000000000;
         6'h0B: return 14'b00001110001001;
         6'h0C: return 14'b00011100000000;
         6'h0D: return 14'b01101100101000;
         6'h0E: return 14'b01101100100001;
         6'h0F: return 14'b11111100000000;
         6'h10: return 14'b11001111000000;
         6'h11: return 14'b11111100000001;
         6'h12: return 14'b11001111000001;
         6'h13: return 14'b10110111000000;
         6'h14: return 14'b10000000010010;
         6'h15: return 14'b01111100000000;
         6'h16: return 14'b00001100001100;
         6'h17: return 14'b01101100000101;
         6'h18: return 14'b00000000101101;
         6'h19: return 14'b00000000101010;
         6'h1A: return 14'b10010000001100;
         6'h1B: return 14'b10101011000000;
         6'h1C: return 14'b11111100001100;
         6'h1D: return 14'b01100000001000;
         6'h1E: return 14'b11011011000000;
         6'h1F: return 14'b11110011000000;
         6'h20: return 14'b01100111000000;
         6'h21: return 14'b10010110000001;
         6'h22: return 14'b10111111000000;
         6'h23: return 14'b11100000000000;
         6'h24: return 14'b11111111000000;
         6'h25: return 14'b11110111000000;
         default: return 14'b0;
      endcase
   endfunction

   // Window start after a given number of steps, derived from the scroll rules.
   function automatic int offset_of(input int steps, input int len);
      int span, per, p;
`ifdef SCROLL_PINGPONG_EN
      span = len - NDIG;
      per  = 2 * span;
      p    = steps % per;
      return (p > span) ? per - p : p;
`else
      span = 0;
      per  = 0;
      p    = 0;
      return steps % len;
`endif
   endfunction

   function automatic logic [13:0] exp_segm(input int d);
      if (len_m == 0 || d >= NDIG) return 14'b0;
      if (len_m <= NDIG) return (d >= len_m) ? 14'b0 : font_ref(mem_m[d]);
      return font_ref(mem_m[(offset_of(steps_m, len_m) + d) % len_m]);
   endfunction

   // One clock: predict from pre-edge state, advance the model at the edge, check 1 time unit later.
   task automatic cycle(input string tag);
      logic [13:0] es;
      logic        et;
      int          cl;
      es = rst_n ? exp_segm(int'(bus.rd_digit)) : 14'b0;
      et = 1'b0;
      if (bus.wr_en)  $display("wr   addr=%0d char=0x%02h", bus.wr_addr, bus.wr_char);
      if (bus.commit) $display("commit len=%0d", bus.commit_len);
      @(posedge clk);
      if (!rst_n) begin
         len_m = 0; cyc_m = 0; steps_m = 0;
      end else if (bus.commit) begin
         cl    = int'(bus.commit_len);
         len_m = (cl > 32) ? 32 : cl;
         cyc_m = 0; steps_m = 0;
      end else if (bus.scroll_en && len_m > NDIG) begin
         cyc_m++;
         if (cyc_m % SCROLL_DIV == 0) begin
            steps_m++;
            et = 1'b1;
         end
      end
      if (bus.wr_en) mem_m[bus.wr_addr] = bus.wr_char;
      #1;
      check_eq({tag, "/segm"}, 32'(bus.rd_segm), 32'(es));
      check_eq({tag, "/tick"}, 32'(bus.step_tick), 32'(et));
   endtask

   task automatic load_visible(input int n);
      for (int a = 0; a < n; a++) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = 5'(a);
         bus.wr_char = 6'($urandom_range(1, 37));
         cycle("load");
      end
      bus.wr_en = 1'b0;
   endtask

   task automatic do_commit(input int len);
      bus.commit     = 1'b1;
      bus.commit_len = 6'(len);
      cycle("commit");
      bus.commit     = 1'b0;
   endtask

   logic [5:0]  pina_code  [4];
   logic [13:0] pina_glyph [5];

   initial begin
      pina_code  = '{6'h10, 6'h09, 6'h1B, 6'h01};
      pina_glyph = '{14'b11001111000000, 14'b10010000010010, 14'b10101011000000,
                     14'b11101111000000, 14'b0};
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_char = '0;
      bus.commit = 1'b0; bus.commit_len = '0; bus.scroll_en = 1'b0; bus.rd_digit = '0;

      // Reset state, then empty message blanks every position
      repeat (2) cycle("reset");
      #2 rst_n = 1'b1;
      for (int d = 0; d < 16; d++) begin
         bus.rd_digit = 4'(d);
         cycle("len0");
      end

      // Fill RAM, then PINA with the last write and commit in the same cycle
      load_visible(32);
      for (int i = 0; i < 4; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = 5'(i);
         bus.wr_char = pina_code[i];
         if (i == 3) begin
            bus.commit = 1'b1; bus.commit_len = 6'd4;
         end
         cycle("pina_wr");
      end
      bus.wr_en = 1'b0; bus.commit = 1'b0;
      for (int d = 0; d < 5; d++) begin
         bus.rd_digit = 4'(d);
         cycle("pina_rd");
         check_eq("pina_glyph", 32'(bus.rd_segm), 32'(pina_glyph[d]));
      end

      // len=14 scrolling: one step every SCROLL_DIV cycles
      load_visible(14);
      do_commit(14);
      bus.scroll_en = 1'b1;
      bus.rd_digit  = 4'd0;
      tick_cnt = 0;
      for (int c = 0; c < 14 * SCROLL_DIV; c++) begin
         cycle("scroll14");
         if (bus.step_tick) tick_cnt++;
      end
      check_eq("tick_count14", 32'(tick_cnt), 32'd14);
`ifndef SCROLL_PINGPONG_EN
      cycle("wrap14");
      check_eq("wrap14_digit0", 32'(bus.rd_segm), 32'(font_ref(mem_m[0])));
`endif

      // Commit coinciding with a divider wrap wins
      for (int c = 0; c < 16 && ((cyc_m + 1) % SCROLL_DIV) != 0; c++) cycle("prewrap");
      do_commit(14);
      check_eq("wrap_commit_tick", 32'(bus.step_tick), 32'd0);
      cycle("post_commit");
      check_eq("wrap_commit_d0", 32'(bus.rd_segm), 32'(font_ref(mem_m[0])));

      // Randomized traffic
      for (int c = 0; c < 800; c++) begin
         bus.wr_en      = ($urandom_range(0, 3) == 0);
         bus.wr_addr    = 5'($urandom_range(0, 31));
         bus.wr_char    = 6'($urandom_range(0, 63));
         bus.commit     = ($urandom_range(0, 49) == 0);
         bus.commit_len = 6'($urandom_range(0, 40));
         bus.scroll_en  = ($urandom_range(0, 3) != 0);
         bus.rd_digit   = 4'($urandom_range(0, 15));
         cycle("rand");
      end
      bus.wr_en = 1'b0; bus.commit = 1'b0;

      // Asynchronous reset mid-scroll, between clock edges
      bus.scroll_en = 1'b1;
      load_visible(20);
      do_commit(20);
      bus.rd_digit = 4'd0;
      repeat (10) cycle("pre_rst");
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_rst_segm", 32'(bus.rd_segm), 32'd0);
      check_eq("async_rst_tick", 32'(bus.step_tick), 32'd0);
      repeat (2) cycle("in_rst");
      #2 rst_n = 1'b1;
      for (int d = 0; d < 16; d++) begin
         bus.rd_digit = 4'(d);
         cycle("post_rst");
      end
      do_commit(20);
      bus.rd_digit = 4'd0;
      repeat (3 * SCROLL_DIV) cycle("restart");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/disp_scroll_buf.md
DISP_SCROLL_BUF -- requirements
Module: disp_scroll_buf

Interface
REQ-001 SHALL have parameter SCROLL_DIV, default 1000000, clk cycles per scroll step (legal range 2 to 2^24).
REQ-002 SHALL have parameter NDIG, default 12, number of display digit positions.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port wr_en  input  1  message RAM write strobe.
REQ-006 SHALL have port wr_addr  input  5  message RAM address, 0-31.
REQ-007 SHALL have port wr_char  input  6  character code to write.
REQ-008 SHALL have port commit  input  1  one-cycle strobe that latches the message length.
REQ-009 SHALL have port commit_len  input  6  new message length, 0-32; values above 32 are clamped to 32.
REQ-010 SHALL have port scroll_en  input  1  enables scrolling.
REQ-011 SHALL have port rd_digit  input  4  digit position requested by the downstream scanner, 0 to NDIG-1.
REQ-012 SHALL have port rd_segm  output  14  14-segment pattern, MSB first, in the team segment order.
REQ-013 SHALL have port step_tick  output  1  one-cycle pulse whenever the scroll offset changes.

Function
REQ-014 SHALL hold a 32x6 message RAM; a write on wr_en SHALL be visible to reads starting the following cycle.
REQ-015 SHALL decode codes as follows: 0x00 space, 0x01-0x1A A-Z, 0x1B Ñ, 0x1C-0x25 digits 0-9, and 0x26-0x3F blank (all zeros).
REQ-016 SHALL use these font values: A=14'b11101111000000, I=14'b10010000010010, P=14'b11001111000000, Ñ=14'b10101011000000, space=0; all other glyphs SHALL come from the team 14-segment font table.
REQ-017 SHALL register rd_segm so that it reflects font(msg[idx]) one clk after rd_digit is sampled (1-cycle latency).
REQ-018 SHALL use idx = rd_digit when len <= NDIG, and SHALL output blank when rd_digit >= len.
REQ-019 SHALL compute idx = (offset + rd_digit) mod len when len > NDIG, using a single conditional subtract.
REQ-020 SHALL output blank for any rd_digit >= NDIG, and SHALL output blank at every position when len = 0.
REQ-021 SHALL run a divider counting 0 to SCROLL_DIV-1 while scroll_en=1 and len > NDIG; the divider SHALL hold its value while scroll_en=0.
REQ-022 SHALL advance offset by one step and pulse step_tick on divider wrap; offset SHALL wrap from len-1 to 0.
REQ-023 SHALL, on commit, latch len, clear offset and divider to 0, and suppress step_tick that cycle; commit SHALL win over a simultaneous divider wrap.
REQ-024 SHALL let wr_en and commit occur in the same cycle, with the write landing before the new len applies on the next cycle.
REQ-025 SHALL keep offset at 0 with no step_tick while len <= NDIG.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear len, offset, divider, rd_segm and step_tick to 0, and clear the direction flag to up.
REQ-027 SHALL NOT reset RAM contents; they are don't-care because len=0 blanks the display.
REQ-028 SHALL, if reset occurs mid-scroll, restart from offset 0 once rst_n deasserts, and only after a new commit.

Configuration
REQ-029 SHALL, when macro SCROLL_PINGPONG_EN is defined, bounce offset between 0 and len-NDIG instead of wrapping: the direction flag reverses at each end, and each reversal step pulses step_tick.
REQ-030 SHALL, without SCROLL_PINGPONG_EN, use modulo wrap per REQ-022 and omit the direction flag entirely.

Verification
REQ-031 SHALL cover: write "PIÑA" (0x10,0x09,0x1B,0x01), commit len=4, read digits 0-4 -> P, I, Ñ, A, blank, each one cycle after the request.
REQ-032 SHALL cover: len=0 after reset, sweep rd_digit 0-15 -> rd_segm=0 throughout.
REQ-033 SHALL cover: SCROLL_DIV=4, len=14, scroll_en=1 -> step_tick every 4 cycles, and offset wraps 13->0 so digit 0 shows msg[0] again after 14 steps.
REQ-034 SHALL cover: commit in the same cycle as a divider wrap -> offset=0, no step_tick, and digit 0 shows msg[0].
REQ-035 SHALL cover: rst_n pulsed low mid-scroll, asynchronously between edges -> rd_segm=0 immediately and len=0.
REQ-036 SHALL cover, with SCROLL_PINGPONG_EN: len=14 -> offset sequence 0,1,2,1,0,1 across step_ticks.
